// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//
// Circular in-order retirement buffer for a register-renaming core. Renamed
// instructions are dispatched at the tail and receive the tail index as
// their tag. Execution units mark entries done by tag. The head entry
// retires once it is done. On retirement, the destination's previous
// physical mapping is offered back to the free pool.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               discard every in-flight entry on the next edge
//   dispatch_*          producer handshake; dispatch_tag is the tail index
//   complete_valid/tag  mark an in-flight entry as finished
//   commit_stall        consumer back-pressure on retirement
//   commit_valid        head entry retires this cycle
//   commit_prd_new      retiring destination physical register
//   commit_free/prd_free physical register to return to the free pool
//   rob_count/empty/full occupancy status
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int NUM_REG      = 32,
    parameter int NUM_REG_LOG2 = $clog2(NUM_REG),
    parameter int ROB_DEPTH    = 16,
    parameter int ROB_LOG2     = $clog2(ROB_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    dispatch_valid,
    output logic                    dispatch_ready,
    input  logic                    dispatch_rd_valid,
    input  logic [NUM_REG_LOG2:0]   dispatch_prd_old,
    input  logic [NUM_REG_LOG2:0]   dispatch_prd_new,
    output logic [ROB_LOG2-1:0]     dispatch_tag,
    input  logic                    complete_valid,
    input  logic [ROB_LOG2-1:0]     complete_tag,
    input  logic                    commit_stall,
    output logic                    commit_valid,
    output logic [NUM_REG_LOG2:0]   commit_prd_new,
    output logic                    commit_free,
    output logic [NUM_REG_LOG2:0]   prd_free,
    output logic [ROB_LOG2:0]       rob_count,
    output logic                    rob_empty,
    output logic                    rob_full
);

    localparam logic [ROB_LOG2:0] PTR_ONE = {{ROB_LOG2{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so that full and empty are distinct.
    logic [ROB_LOG2:0]      head;
    logic [ROB_LOG2:0]      tail;
    logic [ROB_LOG2-1:0]    head_idx;
    logic [ROB_LOG2-1:0]    tail_idx;

    // Control state (reset) and payload (not reset).
    logic [ROB_DEPTH-1:0]   ent_valid;
    logic [ROB_DEPTH-1:0]   ent_done;
    logic [ROB_DEPTH-1:0]   ent_rd_valid;
    logic [NUM_REG_LOG2:0]  ent_prd_old [ROB_DEPTH];
    logic [NUM_REG_LOG2:0]  ent_prd_new [ROB_DEPTH];

    logic do_dispatch;
    logic do_complete;

    assign head_idx = head[ROB_LOG2-1:0];
    assign tail_idx = tail[ROB_LOG2-1:0];

    assign rob_count = tail - head;
    assign rob_empty = (head == tail);
    assign rob_full  = (head_idx == tail_idx) && (head[ROB_LOG2] != tail[ROB_LOG2]);

    // Readiness looks only at the current occupancy, so a slot freed by a
    // same-cycle commit is not reusable until the next cycle.
    assign dispatch_ready = !rob_full && !flush;
    assign dispatch_tag   = tail_idx;
    assign do_dispatch    = dispatch_valid && dispatch_ready;

    // Completions against empty slots (stale tags after a flush) are dropped.
    assign do_complete = complete_valid && ent_valid[complete_tag];

    always_comb begin
        commit_valid   = ent_valid[head_idx] && ent_done[head_idx] && !commit_stall && !flush;
        commit_free    = 1'b0;
        commit_prd_new = '0;
        prd_free       = '0;
        if (commit_valid) begin
            commit_free    = ent_rd_valid[head_idx];
            commit_prd_new = ent_prd_new[head_idx];
            prd_free       = ent_prd_old[head_idx];
        end
    end

    // Control: pointers and per-entry valid/done. Later assignments win, so
    // a completion on the retiring head is overridden by the commit clear.
    // A dispatch can never target the head slot while it is retiring,
    // because the head is only retirable when the buffer is non-empty and
    // dispatch is blocked when it is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            if (do_complete) begin
                ent_done[complete_tag] <= 1'b1;
            end
            if (commit_valid) begin
                ent_valid[head_idx] <= 1'b0;
                ent_done[head_idx]  <= 1'b0;
                head                <= head + PTR_ONE;
            end
            if (do_dispatch) begin
                ent_valid[tail_idx] <= 1'b1;
                ent_done[tail_idx]  <= 1'b0;
                tail                <= tail + PTR_ONE;
            end
        end
    end

    // Payload: written on dispatch only; contents of invalid slots are
    // never observed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_dispatch) begin
            ent_rd_valid[tail_idx] <= dispatch_rd_valid;
            ent_prd_old[tail_idx]  <= dispatch_prd_old;
            ent_prd_new[tail_idx]  <= dispatch_prd_new;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//
// Directed bench for reorder_buffer with default parameters (32 registers,
// 16 entries). Inputs change 1 time unit after a rising edge and outputs are
// sampled 1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       dispatch_valid;
    logic       dispatch_ready;
    logic       dispatch_rd_valid;
    logic [5:0] dispatch_prd_old;
    logic [5:0] dispatch_prd_new;
    logic [3:0] dispatch_tag;
    logic       complete_valid;
    logic [3:0] complete_tag;
    logic       commit_stall;
    logic       commit_valid;
    logic [5:0] commit_prd_new;
    logic       commit_free;
    logic [5:0] prd_free;
    logic [4:0] rob_count;
    logic       rob_empty;
    logic       rob_full;

    int checks = 0;
    int errors = 0;

    reorder_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .dispatch_valid    (dispatch_valid),
        .dispatch_ready    (dispatch_ready),
        .dispatch_rd_valid (dispatch_rd_valid),
        .dispatch_prd_old  (dispatch_prd_old),
        .dispatch_prd_new  (dispatch_prd_new),
        .dispatch_tag      (dispatch_tag),
        .complete_valid    (complete_valid),
        .complete_tag      (complete_tag),
        .commit_stall      (commit_stall),
        .commit_valid      (commit_valid),
        .commit_prd_new    (commit_prd_new),
        .commit_free       (commit_free),
        .prd_free          (prd_free),
        .rob_count         (rob_count),
        .rob_empty         (rob_empty),
        .rob_full          (rob_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " ready"},    32'(dispatch_ready), 1);
        chk({tag, " empty"},    32'(rob_empty),      1);
        chk({tag, " full"},     32'(rob_full),       0);
        chk({tag, " count"},    32'(rob_count),      0);
        chk({tag, " cvalid"},   32'(commit_valid),   0);
        chk({tag, " cfree"},    32'(commit_free),    0);
        chk({tag, " prd_free"}, 32'(prd_free),       0);
        chk({tag, " prd_new"},  32'(commit_prd_new), 0);
        chk({tag, " tag"},      32'(dispatch_tag),   0);
    endtask

    task automatic set_disp(input logic v, input logic rdv, input int old_p, input int new_p);
        dispatch_valid    = v;
        dispatch_rd_valid = rdv;
        dispatch_prd_old  = 6'(old_p);
        dispatch_prd_new  = 6'(new_p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b0;
        flush          = 1'b0;
        complete_valid = 1'b0;
        complete_tag   = '0;
        commit_stall   = 1'b0;
        set_disp(1'b0, 1'b0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk_idle("reset");
        #10 rst = 1'b0;
        step();
        chk_idle("post_reset");

        // Three dispatches, tags 0..2
        for (int i = 0; i < 3; i++) begin
            set_disp(1'b1, 1'b1, 5 + i, 32 + i);
            #1;
            chk($sformatf("disp3 tag%0d", i), 32'(dispatch_tag), i);
            step();
        end
        set_disp(1'b0, 1'b0, 0, 0);
        #1;
        chk("disp3 count",  32'(rob_count),    3);
        chk("disp3 cvalid", 32'(commit_valid), 0);

        // Out-of-order completion 2, 1, 0; in-order retirement
        complete_valid = 1'b1;
        complete_tag   = 4'd2;
        step();
        complete_tag   = 4'd1;
        step();
        complete_tag   = 4'd0;
        #1;
        chk("ooo no commit", 32'(commit_valid), 0);
        step();
        complete_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("ret%0d cvalid", i),   32'(commit_valid),   1);
            chk($sformatf("ret%0d cfree", i),    32'(commit_free),    1);
            chk($sformatf("ret%0d prd_free", i), 32'(prd_free),       5 + i);
            chk($sformatf("ret%0d prd_new", i),  32'(commit_prd_new), 32 + i);
            step();
        end
        #1;
        chk("drained empty",  32'(rob_empty),    1);
        chk("drained cvalid", 32'(commit_valid), 0);

        // rd_valid=0 head and commit_stall (head/tail now at 3)
        set_disp(1'b1, 1'b0, 9, 40);
        #1;
        chk("nord tag", 32'(dispatch_tag), 3);
        step();
        set_disp(1'b0, 1'b0, 0, 0);
        complete_valid = 1'b1;
        complete_tag   = 4'd3;
        commit_stall   = 1'b1;
        step();
        complete_valid = 1'b0;
        #1;
        chk("stall cvalid0", 32'(commit_valid), 0);
        chk("stall prd_free0", 32'(prd_free),   0);
        step();
        chk("stall cvalid1", 32'(commit_valid), 0);
        chk("stall count",   32'(rob_count),    1);
        commit_stall = 1'b0;
        #1;
        chk("nord cvalid",   32'(commit_valid),   1);
        chk("nord cfree",    32'(commit_free),    0);
        chk("nord prd_free", 32'(prd_free),       9);
        chk("nord prd_new",  32'(commit_prd_new), 40);
        step();
        chk("nord empty", 32'(rob_empty), 1);

        // Flush with 5 entries (tags 4..8), 2 of them done
        for (int i = 0; i < 5; i++) begin
            set_disp(1'b1, 1'b1, 10 + i, 41 + i);
            step();
        end
        set_disp(1'b0, 1'b0, 0, 0);
        complete_valid = 1'b1;
        complete_tag   = 4'd5;
        step();
        complete_tag   = 4'd6;
        step();
        complete_valid = 1'b0;
        #1;
        chk("preflush count",  32'(rob_count),    5);
        chk("preflush cvalid", 32'(commit_valid), 0);
        flush = 1'b1;
        #1;
        chk("flush ready", 32'(dispatch_ready), 0);
        chk("flush cfree", 32'(commit_free),    0);
        step();
        flush = 1'b0;
        #1;
        chk("postflush count", 32'(rob_count),    0);
        chk("postflush empty", 32'(rob_empty),    1);
        chk("postflush tag",   32'(dispatch_tag), 0);
        chk("postflush cfree", 32'(commit_free),  0);
        complete_valid = 1'b1;
        complete_tag   = 4'd5;
        step();
        complete_valid = 1'b0;
        #1;
        chk("stale count",  32'(rob_count),    0);
        chk("stale cvalid", 32'(commit_valid), 0);
        chk("stale cfree",  32'(commit_free),  0);

        // Fill to 16 from pointer 0, hold a 17th, retire one, wrap
        for (int i = 0; i < 16; i++) begin
            set_disp(1'b1, 1'b1, i, 32 + i);
            #1;
            chk($sformatf("fill tag%0d", i), 32'(dispatch_tag), i);
            step();
        end
        set_disp(1'b1, 1'b1, 20, 52);
        #1;
        chk("full flag",  32'(rob_full),       1);
        chk("full ready", 32'(dispatch_ready), 0);
        chk("full count", 32'(rob_count),      16);
        complete_valid = 1'b1;
        complete_tag   = 4'd0;
        step();
        complete_valid = 1'b0;
        #1;
        chk("held count",    32'(rob_count),      16);
        chk("held tag",      32'(dispatch_tag),   0);
        chk("held ready",    32'(dispatch_ready), 0);
        chk("held cvalid",   32'(commit_valid),   1);
        chk("held prd_free", 32'(prd_free),       0);
        chk("held prd_new",  32'(commit_prd_new), 32);
        step();
        chk("wrap ready", 32'(dispatch_ready), 1);
        chk("wrap count", 32'(rob_count),      15);
        chk("wrap tag",   32'(dispatch_tag),   0);
        step();
        set_disp(1'b0, 1'b0, 0, 0);
        #1;
        chk("wrap refull", 32'(rob_full),     1);
        chk("wrap count2", 32'(rob_count),    16);
        chk("wrap tag2",   32'(dispatch_tag), 1);
        chk("wrap cvalid", 32'(commit_valid), 0);

        // Asynchronous reset between edges with 4 entries, head done
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_disp(1'b1, 1'b1, 1 + i, 50 + i);
            step();
        end
        set_disp(1'b0, 1'b0, 0, 0);
        complete_valid = 1'b1;
        complete_tag   = 4'd0;
        step();
        complete_valid = 1'b0;
        #1;
        chk("prerst count",  32'(rob_count),    4);
        chk("prerst cvalid", 32'(commit_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk_idle("async_rst");
        step();
        chk_idle("rst_held");
        rst = 1'b0;
        step();
        chk_idle("rst_released");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
